// File: rtl/mac_accumulator.sv
// mac_accumulator
// Accumulate stage behind the 4x4 array multiplier. Unsigned products arrive
// over a valid/ready handshake and are summed into an ACC_W-bit register. A
// group ends on in_last or when MAX_TERMS products have been taken. The sum,
// term count and sticky overflow flag are then held on the out_* outputs
// until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the current group (highest priority)
//   in_valid   in_prod / in_last are valid
//   in_ready   block accepts a product this cycle (state ACC)
//   in_prod    unsigned product, PROD_W bits
//   in_last    final product of the group
//   out_valid  result is held on out_* (state DONE)
//   out_ready  consumer takes the result
//   out_sum    accumulated sum, ACC_W bits
//   out_count  number of products in the group, CNT_W bits
//   out_ovf    sticky: at least one add carried out of ACC_W
//
// Build option: define MAC_ACCUMULATOR_SAT_EN to saturate the accumulator at
// 2^ACC_W-1 on carry-out instead of wrapping modulo 2^ACC_W.
//
// state | meaning
// ------+----------------------------------------------------------
// ACC   | accepting products, out_sum/out_count show running values
// DONE  | group complete, outputs held until out_ready

module mac_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [CNT_W-1:0]   count_inc;

    // One extra bit on the adder exposes the carry-out for the sticky flag.
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign carry     = sum_ext[ACC_W];
    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_ACC) begin
            if (in_valid) begin
`ifdef MAC_ACCUMULATOR_SAT_EN
                // Once saturated, further adds either carry again or add 0,
                // so the accumulator stays pinned at full scale.
                acc_d = carry ? '1 : sum_ext[ACC_W-1:0];
`else
                acc_d = sum_ext[ACC_W-1:0];
`endif
                count_d = count_inc;
                ovf_d   = ovf_q | carry;
                if (in_last || (count_inc == CNT_W'(MAX_TERMS))) begin
                    state_d = ST_DONE;
                end
            end
        end else if (out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Every output is a flop or a decode of the state flop only.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule
